divider32_fp: RTL and testbench



---
 rtl/divider32_fp.sv | 353 +++++++++++++++++++++++++++++++++++
 tb/tb_divider32_fp.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider32_fp.sv
// Sequential binary32 divider: radix-2 restoring mantissa divide, round-to-nearest-even.
// Define DIV32FP_SUBNORMAL_EN for gradual underflow; the default build flushes subnormals to zero.
module divider32_fp (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] quotient_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        nan_o,
  output logic        infinit_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        div_zero_o
);

  localparam int unsigned EXP_W  = 10;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned REM_W  = 25;
  localparam int unsigned QUO_W  = 26;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned ITERS  = 26;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRENORM, S_DIVIDE, S_NORM, S_ROUND, S_FINAL, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [31:0]              a_q, a_d, b_q, b_d;
  logic                     sign_q, sign_d;
  logic signed [EXP_W-1:0]  e_q, e_d;
  logic [MANT_W-1:0]        ma_q, ma_d, mb_q, mb_d;
  logic [REM_W-1:0]         rem_q, rem_d;
  logic [QUO_W-1:0]         q_q, q_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [MANT_W-1:0]        m_q, m_d;
  logic                     g_q, g_d, sticky_q, sticky_d;
  logic                     tiny_q, tiny_d, inexact_q, inexact_d;
  logic                     special_q, special_d;
  logic [31:0]              spec_res_q, spec_res_d;
  logic                     spec_nan_q, spec_nan_d, spec_inf_q, spec_inf_d, spec_dz_q, spec_dz_d;
  logic [31:0]              quotient_q, quotient_d;
  logic                     done_q, done_d, busy_q, busy_d;
  logic                     nan_q, nan_d, inf_q, inf_d, ovf_q, ovf_d, unf_q, unf_d, dz_q, dz_d;

  logic [7:0]               exp_a, exp_b;
  logic [22:0]              frac_a, frac_b;
  logic                     a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic [MANT_W-1:0]        ma_ld, mb_ld;
  logic [EXP_W-1:0]         ea_eff, eb_eff;
  logic [REM_W-1:0]         rem_cur, diff;
  logic                     ge, round_up;
  logic [MANT_W:0]          sum;

`ifdef DIV32FP_SUBNORMAL_EN
  logic [4:0]               lz_a, lz_b, sh_c;
  logic [EXP_W-1:0]         sh_amt;
  logic [2*REM_W-1:0]       den_ext;
  logic [MANT_W-1:0]        den_m;
  logic                     den_g, den_st;

  function automatic logic [4:0] lead_zeros(input logic [MANT_W-1:0] m);
    lead_zeros = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (m[i]) lead_zeros = 5'(23 - i);
    end
  endfunction
`endif

  // Operand classification from the captured operands
  always_comb begin
    exp_a  = a_q[30:23];
    exp_b  = b_q[30:23];
    frac_a = a_q[22:0];
    frac_b = b_q[22:0];
    a_nan  = (&exp_a) & (|frac_a);
    a_inf  = (&exp_a) & ~(|frac_a);
    b_nan  = (&exp_b) & (|frac_b);
    b_inf  = (&exp_b) & ~(|frac_b);
`ifdef DIV32FP_SUBNORMAL_EN
    a_zero = ~(|exp_a) & ~(|frac_a);
    b_zero = ~(|exp_b) & ~(|frac_b);
    ma_ld  = {|exp_a, frac_a};
    mb_ld  = {|exp_b, frac_b};
    ea_eff = (|exp_a) ? EXP_W'(exp_a) : EXP_W'(1);
    eb_eff = (|exp_b) ? EXP_W'(exp_b) : EXP_W'(1);
`else
    a_zero = ~(|exp_a);
    b_zero = ~(|exp_b);
    ma_ld  = {1'b1, frac_a};
    mb_ld  = {1'b1, frac_b};
    ea_eff = EXP_W'(exp_a);
    eb_eff = EXP_W'(exp_b);
`endif
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    e_d        = e_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    rem_d      = rem_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    m_d        = m_q;
    g_d        = g_q;
    sticky_d   = sticky_q;
    tiny_d     = tiny_q;
    inexact_d  = inexact_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    spec_nan_d = spec_nan_q;
    spec_inf_d = spec_inf_q;
    spec_dz_d  = spec_dz_q;
    quotient_d = quotient_q;
    nan_d      = nan_q;
    inf_d      = inf_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    dz_d       = dz_q;
    rem_cur    = '0;
    diff       = '0;
    ge         = 1'b0;
    round_up   = 1'b0;
    sum        = '0;
`ifdef DIV32FP_SUBNORMAL_EN
    lz_a       = lead_zeros(ma_q);
    lz_b       = lead_zeros(mb_q);
    sh_amt     = '0;
    sh_c       = '0;
    den_ext    = '0;
    den_m      = '0;
    den_g      = 1'b0;
    den_st     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          nan_d   = 1'b0;
          inf_d   = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          dz_d    = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        sign_d     = a_q[31] ^ b_q[31];
        ma_d       = ma_ld;
        mb_d       = mb_ld;
        e_d        = $signed(ea_eff - eb_eff + EXP_W'(127));
        cnt_d      = '0;
        tiny_d     = 1'b0;
        inexact_d  = 1'b0;
        special_d  = 1'b1;
        spec_nan_d = 1'b0;
        spec_inf_d = 1'b0;
        spec_dz_d  = 1'b0;
        spec_res_d = {sign_d, 31'd0};
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
          spec_res_d = 32'h7FC0_0000;
          spec_nan_d = 1'b1;
        end else if (a_inf) begin
          spec_res_d = {sign_d, 31'h7F80_0000};
          spec_inf_d = 1'b1;
        end else if (b_zero) begin
          spec_res_d = {sign_d, 31'h7F80_0000};
          spec_inf_d = 1'b1;
          spec_dz_d  = 1'b1;
        end else if (!(a_zero | b_inf)) begin
          special_d  = 1'b0;
        end
`ifdef DIV32FP_SUBNORMAL_EN
        state_d = special_d ? S_FINAL : S_PRENORM;
`else
        state_d = special_d ? S_FINAL : S_DIVIDE;
`endif
      end
      S_PRENORM: begin
`ifdef DIV32FP_SUBNORMAL_EN
        ma_d = ma_q << lz_a;
        mb_d = mb_q << lz_b;
        e_d  = e_q - $signed(EXP_W'(lz_a)) + $signed(EXP_W'(lz_b));
`endif
        state_d = S_DIVIDE;
      end
      S_DIVIDE: begin
        rem_cur = (cnt_q == '0) ? {1'b0, ma_q} : rem_q;
        ge      = (rem_cur >= {1'b0, mb_q});
        diff    = ge ? (rem_cur - {1'b0, mb_q}) : rem_cur;
        q_d     = {q_q[QUO_W-2:0], ge};
        rem_d   = {diff[REM_W-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) state_d = S_NORM;
      end
      S_NORM: begin
        if (q_q[QUO_W-1]) begin
          m_d      = q_q[QUO_W-1:2];
          g_d      = q_q[1];
          sticky_d = q_q[0] | (|rem_q);
        end else begin
          m_d      = q_q[QUO_W-2:1];
          g_d      = q_q[0];
          sticky_d = |rem_q;
          e_d      = e_q - 10'sd1;
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        round_up = g_q & (sticky_q | m_q[0]);
        sum      = {1'b0, m_q} + {{MANT_W{1'b0}}, round_up};
        if (sum[MANT_W]) begin
          m_d = sum[MANT_W:1];
          e_d = e_q + 10'sd1;
        end else begin
          m_d = sum[MANT_W-1:0];
        end
`ifdef DIV32FP_SUBNORMAL_EN
        // Tiny result: denormalize before rounding so the rounding sees the real LSB
        if (e_q <= 10'sd0) begin
          sh_amt    = 10'sd1 - e_q;
          sh_c      = (sh_amt > EXP_W'(26)) ? 5'd26 : sh_amt[4:0];
          den_ext   = {m_q, g_q, 25'd0} >> sh_c;
          den_m     = den_ext[2*REM_W-1:REM_W+1];
          den_g     = den_ext[REM_W];
          den_st    = (|den_ext[REM_W-1:0]) | sticky_q;
          m_d       = den_m + MANT_W'(den_g & (den_st | den_m[0]));
          e_d       = e_q;
          tiny_d    = 1'b1;
          inexact_d = den_g | den_st;
        end
`endif
        state_d = S_FINAL;
      end
      S_FINAL: begin
        nan_d = 1'b0;
        inf_d = 1'b0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        dz_d  = 1'b0;
        if (special_q) begin
          quotient_d = spec_res_q;
          nan_d      = spec_nan_q;
          inf_d      = spec_inf_q;
          dz_d       = spec_dz_q;
        end else if (tiny_q) begin
          quotient_d = {sign_q, 7'd0, m_q[MANT_W-1], m_q[MANT_W-2:0]};
          unf_d      = inexact_q;
        end else if (e_q >= 10'sd255) begin
          quotient_d = {sign_q, 31'h7F80_0000};
          ovf_d      = 1'b1;
          inf_d      = 1'b1;
        end else if (e_q <= 10'sd0) begin
          quotient_d = {sign_q, 31'd0};
          unf_d      = 1'b1;
        end else begin
          quotient_d = {sign_q, e_q[7:0], m_q[MANT_W-2:0]};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      e_q        <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      rem_q      <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      m_q        <= '0;
      g_q        <= 1'b0;
      sticky_q   <= 1'b0;
      tiny_q     <= 1'b0;
      inexact_q  <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      spec_nan_q <= 1'b0;
      spec_inf_q <= 1'b0;
      spec_dz_q  <= 1'b0;
      quotient_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      nan_q      <= 1'b0;
      inf_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      e_q        <= e_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      rem_q      <= rem_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      m_q        <= m_d;
      g_q        <= g_d;
      sticky_q   <= sticky_d;
      tiny_q     <= tiny_d;
      inexact_q  <= inexact_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      spec_nan_q <= spec_nan_d;
      spec_inf_q <= spec_inf_d;
      spec_dz_q  <= spec_dz_d;
      quotient_q <= quotient_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      nan_q      <= nan_d;
      inf_q      <= inf_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      dz_q       <= dz_d;
    end
  end

  assign quotient_o  = quotient_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign nan_o       = nan_q;
  assign infinit_o   = inf_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign div_zero_o  = dz_q;

endmodule

// File: tb/tb_divider32_fp.sv
// Scoreboard bench for divider32_fp: directed and random divisions against an integer reference model.
module tb_divider32_fp;

`ifdef DIV32FP_SUBNORMAL_EN
  localparam int LAT_N = 31;
`else
  localparam int LAT_N = 30;
`endif
  localparam int LAT_S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] a_i, b_i;
  logic [31:0] quotient_o;
  logic        done_o, busy_o, nan_o, infinit_o, overflow_o, underflow_o, div_zero_o;

  divider32_fp dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .quotient_o  (quotient_o),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .nan_o       (nan_o),
    .infinit_o   (infinit_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o),
    .div_zero_o  (div_zero_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // flags ordered {nan, inf, ovf, unf, dz}
  typedef struct {
    logic [31:0] q;
    logic [4:0]  flags;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [4:0] flags_now();
    return {nan_o, infinit_o, overflow_o, underflow_o, div_zero_o};
  endfunction

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic exp_t mk(input string nm, input logic [31:0] q, input logic [4:0] f, input int lat);
    exp_t r;
    r.q = q; r.flags = f; r.lat = lat; r.acc = 0; r.name = nm;
    return r;
  endfunction

  // Reference: exact integer division of the significands, then RNE rounding
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t             r;
    logic             s;
    logic [7:0]       ea, eb;
    logic [22:0]      fa, fb;
    bit               an, ai, az, bn, bi, bz, g, st;
    longint unsigned  num, den, n, rr, mant;
    int               p, e;
    r = mk("rand", 32'd0, 5'b0, LAT_S);
    s = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
    an = (ea == 8'hFF) && (fa != 0); ai = (ea == 8'hFF) && (fa == 0); az = (ea == 8'h00);
    bn = (eb == 8'hFF) && (fb != 0); bi = (eb == 8'hFF) && (fb == 0); bz = (eb == 8'h00);
    if (an || bn || (az && bz) || (ai && bi)) begin
      r.q = 32'h7FC00000; r.flags = 5'b10000;
    end else if (ai) begin
      r.q = {s, 31'h7F800000}; r.flags = 5'b01000;
    end else if (bz) begin
      r.q = {s, 31'h7F800000}; r.flags = 5'b01001;
    end else if (az || bi) begin
      r.q = {s, 31'd0};
    end else begin
      r.lat = LAT_N;
      num  = 64'({1'b1, fa}) << 32;
      den  = 64'({1'b1, fb});
      n    = num / den;
      rr   = num % den;
      p    = n[32] ? 32 : 31;
      mant = n >> (p - 23);
      g    = n[p - 24];
      st   = ((n & ((64'd1 << (p - 24)) - 64'd1)) != 0) || (rr != 0);
      e    = int'(ea) - int'(eb) + p + 95;
      if (g && (st || mant[0])) mant = mant + 64'd1;
      if (mant[24]) begin
        mant = mant >> 1;
        e = e + 1;
      end
      if (e >= 255) begin
        r.q = {s, 31'h7F800000}; r.flags = 5'b01100;
      end else if (e <= 0) begin
        r.q = {s, 31'd0}; r.flags = 5'b00010;
      end else begin
        r.q = {s, 8'(e), mant[22:0]};
      end
    end
    return r;
  endfunction

  // Monitor: pop and compare on every done pulse
  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done with q=0x%08h, expected none", quotient_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".q"}, quotient_o, e.q);
        check({e.name, ".flags"}, 32'(flags_now()), 32'(e.flags));
        check({e.name, ".lat"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  // Wait for IDLE, present one start, optionally register the expectation
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e, input bit push);
    int w;
    w = 0;
    while (busy_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (busy_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: busy still 1, expected 0");
    end
    start_i = 1'b1;
    a_i = a;
    b_i = b;
    e.acc = cyc + 1;
    if (push) sb.push_back(e);
    n_vec++;
    @(negedge clk);
    start_i = 1'b0;
    check({e.name, ".flags_clr"}, 32'(flags_now()), 32'd0);
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (!done_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!done_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: done_o 0, expected 1");
    end
  endtask

  logic [31:0] pool [8];

  initial begin
    logic [31:0] a, b;
    int w;
    rst = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0;
    pool[0] = 32'h00000000; pool[1] = 32'h80000000; pool[2] = 32'h7F800000; pool[3] = 32'hFF800000;
    pool[4] = 32'h7FC00001; pool[5] = 32'h00000123; pool[6] = 32'h3F800000; pool[7] = 32'hC1200000;
    repeat (3) @(negedge clk);
    check("rst.q", quotient_o, 32'd0);
    check("rst.ctl", {30'd0, done_o, busy_o}, 32'd0);
    check("rst.flags", 32'(flags_now()), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'h41200000, 32'h40800000, mk("ten_by_four", 32'h40200000, 5'b00000, LAT_N), 1);
    issue(32'h3F800000, 32'h40400000, mk("one_third", 32'h3EAAAAAB, 5'b00000, LAT_N), 1);
    issue(32'hC0400000, 32'h40000000, mk("neg_3_by_2", 32'hBFC00000, 5'b00000, LAT_N), 1);
    issue(32'h3F800000, 32'h00000000, mk("div_zero", 32'h7F800000, 5'b01001, LAT_S), 1);
    issue(32'h00000000, 32'h00000000, mk("zero_zero", 32'h7FC00000, 5'b10000, LAT_S), 1);
    issue(32'h7F7FFFFF, 32'h00800000, mk("overflow", 32'h7F800000, 5'b01100, LAT_N), 1);
    issue(32'h00800000, 32'h7F7FFFFF, mk("underflow", 32'h00000000, 5'b00010, LAT_N), 1);
    issue(32'h7F800000, 32'h40000000, mk("inf_by_fin", 32'h7F800000, 5'b01000, LAT_S), 1);
    issue(32'hC0000000, 32'h7F800000, mk("fin_by_inf", 32'h80000000, 5'b00000, LAT_S), 1);

    // start during DIVIDE must be ignored
    issue(32'h40E00000, 32'h40000000, mk("ign_divide", 32'h40600000, 5'b00000, LAT_N), 1);
    repeat (6) @(negedge clk);
    start_i = 1'b1; a_i = 32'h3F800000; b_i = 32'h00000000;
    @(negedge clk);
    start_i = 1'b0;

    // start during the DONE cycle must be ignored
    wait_done();
    start_i = 1'b1; a_i = 32'h00000000; b_i = 32'h00000000;
    @(negedge clk);
    start_i = 1'b0;

    // reset in DIVIDE cycle 10 drops the operation
    issue(32'h40400000, 32'h3F800000, mk("dropped", 32'h0, 5'b0, LAT_N), 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst.q", quotient_o, 32'd0);
    check("midrst.ctl", {30'd0, done_o, busy_o}, 32'd0);
    check("midrst.flags", 32'(flags_now()), 32'd0);
    rst = 1'b0;
    issue(32'h40A00000, 32'h40000000, mk("after_rst", 32'h40200000, 5'b00000, LAT_N), 1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          a = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
          b = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
        end
        2: begin
          a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
          b = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        end
        default: begin
          a = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
          b = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
        end
      endcase
      issue(a, b, model(a, b), 1);
    end

    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
